reg4_serial_reader: RTL and testbench
=====================================

// Module: reg4_serial_reader
// PURPOSE
//  Read side of the 4-bit register bank. Walks WORDS 4-bit registers through a
//  synchronous address/data read port, one after another. Unloads each nibble
//  LSB-first onto a 1-bit serial stream that uses a valid/ready handshake.
//  Sits between the register bank (parallel store) and the serial debug/result link.
// PARAMETERS
//  WORDS  4  number of 4-bit registers read per run (1..2**AW)
//  AW     2  width of rd_addr
// PORTS
//  clk         in   1   rising-edge clock
//  reset_n     in   1   asynchronous, active-low reset
//  start       in   1   begin a run; sampled only in IDLE
//  rd_addr     out  AW  register select into the bank
//  rd_data     in   4   nibble at rd_addr, valid in the same cycle (combinational bank read)
//  sout        out  1   serial data bit
//  sout_valid  out  1   sout holds a valid bit
//  sout_ready  in   1   sink accepts the bit this cycle
//  busy        out  1   run in progress (FETCH or SHIFT)
//  done        out  1   one-cycle pulse at end of run
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE, rd_addr=0, sout=0, sout_valid=0, busy=0, done=0.
//   - Shift register and bit counter are cleared.
//   - A reset mid-run aborts it immediately: no partial nibble, no done pulse.
//  All outputs are registered. Transitions happen on the clk rising edge.
//  States:
//   - IDLE: if start=1 then rd_addr<=0, busy<=1, go to FETCH.
//   - FETCH (1 cycle): sh<=rd_data, bitcnt<=0, sout<=rd_data[0], sout_valid<=1, go to SHIFT.
//   - SHIFT: a bit transfers only on the cycle where sout_valid&sout_ready.
//       On transfer: sh<=sh>>1, sout<=next bit, bitcnt++.
//       After the last bit of a frame transfers, sout_valid<=0, then:
//         rd_addr==WORDS-1: go to DONE.
//         otherwise: rd_addr++, go to FETCH.
//   - DONE (1 cycle): done=1, busy<=0, go to IDLE.
//  Handshake:
//   - While sout_valid=1 and sout_ready=0, sout and sout_valid hold stable.
//   - sout_ready is ignored while sout_valid=0.
//  start:
//   - Ignored in FETCH, SHIFT and DONE; it is not queued.
//   - Holding start high re-launches from IDLE on the cycle after DONE.
//  Latency:
//   - start sampled at edge E puts the first bit valid after edge E+1.
//   - With sout_ready held at 1, each word costs 1 fetch + 4 bit cycles.
//   - done is high between edges E+5*WORDS and E+5*WORDS+1.
//  Boundaries:
//   - WORDS=1: the run ends after one frame; rd_addr stays 0.
//   - rd_addr never exceeds WORDS-1 and does not wrap inside a run.
//   - rd_addr holds its last value in DONE and in IDLE until the next start.
// CONFIGURATION
//  PARITY_EN defined:
//   - Each frame carries 5 bits: d0 d1 d2 d3 then even parity p = ^nibble.
//   - The parity bit follows the same handshake as the data bits.
//   - Per-word cost becomes 6 cycles; done is high between edges E+6*WORDS and E+6*WORDS+1.
//  PARITY_EN undefined: 4-bit frames only, as described in BEHAVIOUR.
// TESTING
//  1. Reset: drive reset_n=0 mid-SHIFT -> all outputs 0 and state IDLE at once, before any clk edge.
//  2. Bank {0x1,0xA,0x5,0xF}, sout_ready=1, start at E -> stream 1000_0101_1010_1111; done high E+20..E+21 only.
//  3. Same bank, sout_ready toggling 1,0,1,0 -> identical bit stream; sout stable on every ready=0 cycle; no bit dropped or repeated.
//  4. start pulsed again during SHIFT -> ignored; exactly one done; rd_addr sequence 0,1,2,3.
//  5. WORDS=1, rd_data=0x6 -> stream 0110; done at E+5; rd_addr stays 0.
//  6. PARITY_EN, bank {0x7,0x3,...} -> frames 1110_1 and 1100_0; done at E+6*WORDS.

Source files
------------

// File: rtl/reg4_serial_reader.sv
// Walks WORDS 4-bit registers through a read port and streams each nibble LSB-first over valid/ready.
// Optional build macro PARITY_EN appends an even-parity bit to every frame (5-bit frames).
module reg4_serial_reader #(
  parameter int WORDS = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic [AW-1:0] rd_addr,
  input  logic [3:0]    rd_data,
  output logic          sout,
  output logic          sout_valid,
  input  logic          sout_ready,
  output logic          busy,
  output logic          done
);

`ifdef PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  localparam logic [2:0]    LAST_BIT  = 3'(FL - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [FL-1:0]   sh_q, sh_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic            sout_q, sout_d;
  logic            sout_valid_q, sout_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [FL-1:0]   frame_w;

`ifdef PARITY_EN
  assign frame_w = {^rd_data, rd_data};
`else
  assign frame_w = rd_data;
`endif

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    sh_d         = sh_q;
    bitcnt_d     = bitcnt_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_addr_d = '0;
          busy_d    = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        sh_d         = frame_w;
        bitcnt_d     = 3'd0;
        sout_d       = frame_w[0];
        sout_valid_d = 1'b1;
        state_d      = S_SHIFT;
      end
      S_SHIFT: begin
        // Only a handshaken cycle advances; stalls leave every output untouched.
        if (sout_valid_q && sout_ready) begin
          sh_d     = sh_q >> 1;
          sout_d   = sh_q[1];
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == LAST_BIT) begin
            sout_valid_d = 1'b0;
            if (rd_addr_q == LAST_ADDR) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              rd_addr_d = rd_addr_q + AW'(1);
              state_d   = S_FETCH;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      sh_q         <= '0;
      bitcnt_q     <= 3'd0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      sh_q         <= sh_d;
      bitcnt_q     <= bitcnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_reg4_serial_reader.sv
// Scoreboard bench for reg4_serial_reader: a 4-word instance with a modelled bank and a 1-word instance.
// Expected bits/addresses are queued at launch and popped on each handshaken transfer.
module tb_reg4_serial_reader;

`ifdef PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif
  localparam int COST = FL + 1;

  typedef struct packed {
    logic       b;
    logic [1:0] a;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic       sout, sout_valid;
  logic       sout_ready = 1'b1;
  logic       busy, done;

  logic       start1 = 1'b0;
  logic [0:0] rd_addr1;
  logic [3:0] rd_data1;
  logic       sout1, sout_valid1, busy1, done1;

  logic [3:0] bank [4];
  exp_t       sbq [$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  logic       ready_toggle = 1'b0;
  logic       stall_prev = 1'b0;
  logic       prev_sout = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data  = bank[rd_addr];
  assign rd_data1 = 4'h6;

  reg4_serial_reader #(.WORDS(4), .AW(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready), .busy(busy), .done(done)
  );

  reg4_serial_reader #(.WORDS(1), .AW(1)) u_one (
    .clk(clk), .reset_n(reset_n), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .sout(sout1), .sout_valid(sout_valid1), .sout_ready(1'b1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_toggle) sout_ready = ~sout_ready;
    else              sout_ready = 1'b1;
  end

  // Transfer monitor: pops one expectation per handshaken bit, checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(sout_valid), 32'd1);
        check("hold_sout", 32'(sout), 32'(prev_sout));
      end
      if (sout_valid && sout_ready) begin
        if (sbq.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("bit", 32'(sout), 32'(e.b));
          check("addr_seq", 32'(rd_addr), 32'(e.a));
        end
      end
      stall_prev = sout_valid && !sout_ready;
      prev_sout  = sout;
      if (done) done_cnt++;
    end
  end

  task automatic push_run();
    logic [3:0] nib;
    exp_t e;
    for (int w = 0; w < 4; w++) begin
      nib = bank[w];
      for (int b = 0; b < FL; b++) begin
        e.a = 2'(w);
        e.b = (b < 4) ? nib[b] : ^nib;
        sbq.push_back(e);
        $display("[TB] push word %0d bit %0d = %0b", w, b, e.b);
      end
    end
  endtask

  task automatic run4(input logic toggle, input logic check_lat, input logic pulse_again);
    int k, n, d0;
    ready_toggle = toggle;
    @(posedge clk); #2;
    start = 1'b1;
    k  = cyc;
    d0 = done_cnt;
    push_run();
    @(posedge clk); #2;
    start = 1'b0;
    if (pulse_again) begin
      repeat (5) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 400);
    check("done_seen", 32'(done), 32'd1);
    if (check_lat) check("done_cyc", 32'(cyc), 32'(k + 1 + COST * 4));
    check("busy_in_done", 32'(busy), 32'd0);
    check("addr_last", 32'(rd_addr), 32'd3);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    repeat (12) @(negedge clk);
    check("one_done", 32'(done_cnt - d0), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("addr_hold", 32'(rd_addr), 32'd3);
    $display("[TB] run toggle=%0b pulse=%0b done after %0d cycles", toggle, pulse_again, cyc - k);
  endtask

  initial begin
    logic [3:0] one_nib;
    logic       one_bit;
    bank[0] = 4'h1; bank[1] = 4'hA; bank[2] = 4'h5; bank[3] = 4'hF;
    #1;
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_valid", 32'(sout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    run4(1'b0, 1'b1, 1'b0);
    run4(1'b1, 1'b0, 1'b0);
    run4(1'b0, 1'b1, 1'b1);
    bank[0] = 4'h7; bank[1] = 4'h3; bank[2] = 4'hC; bank[3] = 4'h0;
    run4(1'b0, 1'b1, 1'b0);

    // Asynchronous abort mid-run.
    ready_toggle = 1'b0;
    @(posedge clk); #2;
    start = 1'b1;
    push_run();
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("abort_sout", 32'(sout), 32'd0);
    check("abort_valid", 32'(sout_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(rd_addr), 32'd0);
    sbq.delete();
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_stays_idle", 32'({busy, sout_valid, done}), 32'd0);
    $display("[TB] abort checked");

    // Single-word instance.
    one_nib = 4'h6;
    @(posedge clk); #2;
    start1 = 1'b1;
    @(posedge clk); #2;
    start1 = 1'b0;
    @(posedge clk);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      one_bit = (i < 4) ? one_nib[i] : ^one_nib;
      check("one_bit", 32'(sout1), 32'(one_bit));
      check("one_valid", 32'(sout_valid1), 32'd1);
      check("one_addr", 32'(rd_addr1), 32'd0);
    end
    @(negedge clk);
    check("one_done", 32'(done1), 32'd1);
    check("one_busy", 32'(busy1), 32'd0);
    check("one_addr_end", 32'(rd_addr1), 32'd0);
    @(negedge clk);
    check("one_done_pulse", 32'(done1), 32'd0);
    $display("[TB] single-word run checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
